// File: rtl/led_shift_594_pkg.sv
// Shared types and default constants for the 74HC594 chain serializer.
// The refresh option is enabled in the top by defining LED_SHIFT_594_AUTO_REFRESH_EN.
package led_shift_594_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } led_shift_594_state_t;

    localparam int LED_SHIFT_594_NUM_BITS = 128;
    localparam int LED_SHIFT_594_CLK_DIV  = 4;

endpackage

// File: rtl/led_shift_594_phase_timer.sv
// Phase timer: counts CLK_DIV cycles from each restart and flags the last one.
// It saturates at its terminal count instead of wrapping.
module led_shift_594_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic phase_end_o
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (cnt_q != TERM) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_end_o = (cnt_q == TERM);

endmodule

// File: rtl/led_shift_594_serializer.sv
// Shifts a frame MSB-first into a daisy-chained 74HC594 string, then pulses RCLK.
// Define LED_SHIFT_594_AUTO_REFRESH_EN to add a periodic self-started refresh frame.
module led_shift_594_serializer
    import led_shift_594_pkg::*;
#(
    parameter int NUM_BITS = LED_SHIFT_594_NUM_BITS,
    parameter int CLK_DIV  = LED_SHIFT_594_CLK_DIV
`ifdef LED_SHIFT_594_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 1_000_000
`endif
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [NUM_BITS-1:0] frame_data,
    input  logic                frame_update,
    output logic                busy,
    output logic                frame_done,
    output logic                sr_ser,
    output logic                sr_srclk,
    output logic                sr_rclk,
    output logic                sr_clr_n
);

    localparam int BW = $clog2(NUM_BITS + 1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(NUM_BITS);

    led_shift_594_state_t state_q;
    logic [NUM_BITS-1:0]  shreg_q;
    logic [NUM_BITS-1:0]  shreg_d;
    logic [BW-1:0]        bit_cnt_q;
    logic [BW-1:0]        bit_cnt_d;
    logic                 pending_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ser_q;
    logic                 srclk_q;
    logic                 rclk_q;
    logic                 clr_n_q;

    logic phase_end;
    logic phase_restart;
    logic refresh_due;
    logic start_frame;

    assign shreg_d   = shreg_q << 1;
    assign bit_cnt_d = bit_cnt_q - 1'b1;

    assign start_frame = (state_q == IDLE) && (frame_update || pending_q || refresh_due);

    // Every timed state leaves on phase_end, so that edge is also the next state's entry.
    assign phase_restart = (state_q == IDLE) ? start_frame : phase_end;

    led_shift_594_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_phase_timer (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .restart_i  (phase_restart),
        .phase_end_o(phase_end)
    );

`ifdef LED_SHIFT_594_AUTO_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYCLES + 1);
    localparam logic [RW-1:0] REF_TERM = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] refresh_cnt_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            refresh_cnt_q <= '0;
        end else if (start_frame) begin
            refresh_cnt_q <= '0;
        end else if (refresh_cnt_q != REF_TERM) begin
            refresh_cnt_q <= refresh_cnt_q + 1'b1;
        end
    end

    assign refresh_due = (refresh_cnt_q == REF_TERM);
`else
    assign refresh_due = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= CLEAR;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ser_q     <= 1'b0;
            srclk_q   <= 1'b0;
            rclk_q    <= 1'b0;
            clr_n_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Requests that cannot start a frame now are remembered, never dropped.
            if (frame_update && ((state_q == CLEAR) || busy_q)) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                CLEAR: begin
                    if (phase_end) begin
                        clr_n_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (start_frame) begin
                        shreg_q   <= frame_data;
                        ser_q     <= frame_data[NUM_BITS-1];
                        busy_q    <= 1'b1;
                        bit_cnt_q <= BIT_LOAD;
                        pending_q <= 1'b0;
                        state_q   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        srclk_q <= 1'b1;
                        state_q <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        srclk_q   <= 1'b0;
                        bit_cnt_q <= bit_cnt_d;
                        if (bit_cnt_d != '0) begin
                            shreg_q <= shreg_d;
                            ser_q   <= shreg_d[NUM_BITS-1];
                            state_q <= SHIFT_LO;
                        end else begin
                            rclk_q  <= 1'b1;
                            state_q <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        rclk_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ser_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign sr_ser     = ser_q;
    assign sr_srclk   = srclk_q;
    assign sr_rclk    = rclk_q;
    assign sr_clr_n   = clr_n_q;

endmodule

// File: tb/tb_led_shift_594_serializer.sv
// Bench for led_shift_594_serializer: a chain model rebuilds latched frames from the pins
// and is compared with the frames requested, plus pulse widths and busy/gap lengths.
module tb_led_shift_594_serializer;

    localparam int NB  = 8;
    localparam int CD  = 2;
    localparam int NB2 = 128;
    localparam int CD2 = 1;
    localparam int BUSY_LEN  = NB * 2 * CD + CD;
    localparam int BUSY_LEN2 = NB2 * 2 * CD2 + CD2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic [NB-1:0] fd_a = '0;
    logic          fu_a = 1'b0;
    logic          busy_a, done_a, ser_a, srclk_a, rclk_a, clrn_a;

    logic [NB2-1:0] fd_b = '0;
    logic           fu_b = 1'b0;
    logic           busy_b, done_b, ser_b, srclk_b, rclk_b, clrn_b;

    int checks = 0;
    int errors = 0;

    led_shift_594_serializer #(.NUM_BITS(NB), .CLK_DIV(CD)) dut_a (
        .ACLK(clk), .ARESET(rst), .frame_data(fd_a), .frame_update(fu_a),
        .busy(busy_a), .frame_done(done_a), .sr_ser(ser_a), .sr_srclk(srclk_a),
        .sr_rclk(rclk_a), .sr_clr_n(clrn_a)
    );

    led_shift_594_serializer #(.NUM_BITS(NB2), .CLK_DIV(CD2)) dut_b (
        .ACLK(clk), .ARESET(rst), .frame_data(fd_b), .frame_update(fu_b),
        .busy(busy_b), .frame_done(done_b), .sr_ser(ser_b), .sr_srclk(srclk_b),
        .sr_rclk(rclk_b), .sr_clr_n(clrn_b)
    );

    // Chain model for the small instance: what a real 594 string would latch.
    logic [NB-1:0] sh_a = '0;
    int bit_n = 0, busy_run = 0, rclk_run = 0, idle_run = 0, done_bad = 0, starts = 0;
    int clr_req = 0, clr_seen = 0;
    logic after_frame = 1'b0, p_srclk = 1'b0, p_rclk = 1'b0, p_busy = 1'b0;
    logic [NB-1:0] got_q[$];
    logic [NB-1:0] exp_q[$];
    int got_bits_q[$], rclk_w_q[$], busy_len_q[$], gap_q[$];

    always @(negedge clk) begin
        if (clr_seen != clr_req) begin
            clr_seen = clr_req;
            got_q.delete(); got_bits_q.delete(); rclk_w_q.delete();
            busy_len_q.delete(); gap_q.delete();
            done_bad = 0; after_frame = 1'b0;
        end
        if (rst) begin
            bit_n = 0; sh_a = '0; busy_run = 0; rclk_run = 0; idle_run = 0; after_frame = 1'b0;
        end else begin
            if (srclk_a && !p_srclk) begin
                sh_a = {sh_a[NB-2:0], ser_a};
                bit_n++;
            end
            if (rclk_a) rclk_run++;
            if (!rclk_a && p_rclk) begin
                got_q.push_back(sh_a); got_bits_q.push_back(bit_n); rclk_w_q.push_back(rclk_run);
                bit_n = 0; rclk_run = 0;
            end
            if (busy_a && !p_busy) begin
                starts++;
                if (after_frame) gap_q.push_back(idle_run);
            end
            if (busy_a) busy_run++;
            if (!busy_a && p_busy) begin
                busy_len_q.push_back(busy_run);
                busy_run = 0; idle_run = 0; after_frame = 1'b1;
                if (!done_a) done_bad++;
            end else if (done_a) begin
                done_bad++;
            end
            if (!busy_a) idle_run++;
        end
        p_srclk = srclk_a; p_rclk = rclk_a; p_busy = busy_a;
    end

    // Chain model for the wide, CLK_DIV=1 instance.
    logic [NB2-1:0] sh_b = '0;
    logic [NB2-1:0] got_b[$];
    int cyc_b = 0, bits_b = 0, last_rise_b = 0, per_min_b = 1000, per_max_b = 0;
    int busy_run_b = 0, busy_len_b = 0;
    logic p_srclk_b = 1'b0, p_rclk_b = 1'b0, p_busy_b = 1'b0;

    always @(negedge clk) begin
        cyc_b++;
        if (rst) begin
            bits_b = 0; busy_run_b = 0; sh_b = '0;
        end else begin
            if (srclk_b && !p_srclk_b) begin
                if (bits_b > 0) begin
                    if (cyc_b - last_rise_b < per_min_b) per_min_b = cyc_b - last_rise_b;
                    if (cyc_b - last_rise_b > per_max_b) per_max_b = cyc_b - last_rise_b;
                end
                last_rise_b = cyc_b;
                sh_b = {sh_b[NB2-2:0], ser_b};
                bits_b++;
            end
            if (busy_b) busy_run_b++;
            if (!busy_b && p_busy_b) begin
                busy_len_b = busy_run_b; busy_run_b = 0;
            end
            if (!rclk_b && p_rclk_b) got_b.push_back(sh_b);
        end
        p_srclk_b = srclk_b; p_rclk_b = rclk_b; p_busy_b = busy_b;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        clr_req++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_a(input logic [NB-1:0] d);
        @(negedge clk);
        fd_a = d; fu_a = 1'b1;
        @(negedge clk);
        fu_a = 1'b0;
    endtask

    task automatic wait_got(input int k, input int budget);
        int n = 0;
        while (got_q.size() < k && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("frames_arrived", got_q.size() >= k, 1'b1);
    endtask

    task automatic wait_clear_release(input string tag, input int exp_cycles);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!clrn_a && n < 50);
        check(tag, n, exp_cycles);
    endtask

    localparam logic [31:0] PAT = 32'h01234567;

    initial begin
        logic [NB-1:0] d;
        logic [NB2-1:0] pat_b;
        int n, bad, st0, w;

        // Reset values and CLEAR duration.
        repeat (3) @(posedge clk);
        #1;
        check("reset_clr_n", clrn_a, 1'b0);
        check("reset_outputs", {busy_a, done_a, ser_a, srclk_a, rclk_a}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_clear_release("clear_cycles", CD);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if ({busy_a, done_a, ser_a, srclk_a, rclk_a} !== 5'b0 || clrn_a !== 1'b1) bad++;
        end
        check("idle_outputs", bad, 0);

        // Single frame 8'hA5.
        clear_mon();
        pulse_a(8'hA5);
        wait_got(1, 200);
        check("a5_frame", got_q[0], 8'hA5);
        check("a5_srclk_edges", got_bits_q[0], NB);
        check("a5_rclk_width", rclk_w_q[0], CD);
        check("a5_busy_len", busy_len_q[0], BUSY_LEN);
        check("a5_done_pulse", done_bad, 0);
        @(negedge clk);
        check("a5_idle_after", {busy_a, ser_a, srclk_a, rclk_a, clrn_a}, 5'b00001);

        // Second request during the first frame; data changes mid-frame.
        clear_mon();
        pulse_a(8'h3C);
        repeat (9) @(negedge clk);
        pulse_a(8'hFF);
        wait_got(2, 300);
        check("b2b_first", got_q[0], 8'h3C);
        check("b2b_second", got_q[1], 8'hFF);
        check("b2b_gap", gap_q[0], 1);
        check("b2b_busy_len", busy_len_q[1], BUSY_LEN);
        check("b2b_done_pulse", done_bad, 0);

        // Reset mid-frame at bit 4.
        clear_mon();
        pulse_a(8'h96);
        n = 0;
        while (bit_n < 4 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("reach_bit4", bit_n >= 4, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_clr_n", clrn_a, 1'b0);
        check("abort_outputs", {busy_a, done_a, ser_a, srclk_a, rclk_a}, 5'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_clear_release("abort_clear_cycles", CD);
        repeat (40) @(negedge clk);
        check("abort_no_rclk", got_q.size(), 0);
        pulse_a(8'h5A);
        wait_got(1, 200);
        check("after_abort_frame", got_q[0], 8'h5A);
        check("after_abort_bits", got_bits_q[0], NB);

        // Random frames, with new requests both while busy and while idle.
        clear_mon();
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            d = NB'($urandom);
            st0 = starts;
            pulse_a(d);
            exp_q.push_back(d);
            n = 0;
            while (starts == st0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            w = $urandom_range(0, 45);
            repeat (w) begin
                @(negedge clk);
                fd_a = NB'($urandom);
            end
        end
        wait_got(6, 600);
        for (int i = 0; i < 6; i++) check($sformatf("rand_frame%0d", i), got_q[i], exp_q[i]);
        bad = 0;
        foreach (busy_len_q[i]) if (busy_len_q[i] != BUSY_LEN) bad++;
        check("rand_busy_len", bad, 0);
        check("rand_done_pulse", done_bad, 0);

        // Wide chain at CLK_DIV=1.
        pat_b = {~PAT, PAT, ~PAT, PAT};
        @(negedge clk);
        fd_b = pat_b; fu_b = 1'b1;
        @(negedge clk);
        fu_b = 1'b0;
        n = 0;
        while (got_b.size() < 1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("wide_arrived", got_b.size() >= 1, 1'b1);
        check("wide_frame", got_b[0], pat_b);
        check("wide_bits", bits_b, NB2);
        check("wide_busy_len", busy_len_b, BUSY_LEN2);
        check("wide_srclk_min", per_min_b, 2);
        check("wide_srclk_max", per_max_b, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
